// File: rtl/stage_ctrl.sv
// Multi-cycle stage sequencer: FETCH/DECODE/EXEC/MEM/WB/HALT with memory handshake, timeout and sticky error.
// Optional performance counters (cycle_cnt_o, retired_o) are built when STAGE_CTRL_PERF_EN is defined.
module stage_ctrl #(
  parameter int MEM_TIMEOUT = 64,
  parameter int TO_W        = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] itype_i,
  input  logic       mem_ready_i,
  input  logic       halt_i,
  output logic [2:0] stage_o,
  output logic       mem_req_o,
  output logic       mem_we_o,
  output logic       ir_we_o,
  output logic       pc_we_o,
  output logic       wd_q_o,
  output logic [1:0] err_o
`ifdef STAGE_CTRL_PERF_EN
  ,
  output logic [31:0] cycle_cnt_o,
  output logic [31:0] retired_o
`endif
);

  localparam logic [4:0] RTYPE  = 5'd0;
  localparam logic [4:0] ITYPE  = 5'd1;
  localparam logic [4:0] LTYPE  = 5'd2;
  localparam logic [4:0] STYPE  = 5'd3;
  localparam logic [4:0] BTYPE  = 5'd4;
  localparam logic [4:0] UTYPE  = 5'd5;
  localparam logic [4:0] JTYPE  = 5'd6;
  localparam logic [4:0] JRTYPE = 5'd7;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_ILLEGAL = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            req_d, we_d, ir_we_d, pc_we_d, wd_d;
  logic [1:0]      err_d;

  assign stage_o = state_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      to_cnt_q  <= '0;
      mem_req_o <= 1'b0;
      mem_we_o  <= 1'b0;
      ir_we_o   <= 1'b0;
      pc_we_o   <= 1'b0;
      wd_q_o    <= 1'b0;
      err_o     <= ERR_NONE;
    end else begin
      state_q   <= state_d;
      to_cnt_q  <= to_cnt_d;
      mem_req_o <= req_d;
      mem_we_o  <= we_d;
      ir_we_o   <= ir_we_d;
      pc_we_o   <= pc_we_d;
      wd_q_o    <= wd_d;
      err_o     <= err_d;
    end
  end

  // Outputs are registered copies of next-cycle values, so every strobe is one clean cycle.
  always_comb begin
    state_d  = state_q;
    to_cnt_d = to_cnt_q;
    req_d    = 1'b0;
    we_d     = 1'b0;
    ir_we_d  = 1'b0;
    pc_we_d  = 1'b0;
    wd_d     = 1'b0;
    err_d    = err_o;
    case (state_q)
      S_FETCH: begin
        // mem_req_o low means this is the entry cycle: halt is only honoured here.
        if (!mem_req_o) begin
          to_cnt_d = '0;
          if (halt_i) state_d = S_HALT;
          else        req_d   = 1'b1;
        end else if (mem_ready_i) begin
          state_d = S_DECODE;
          ir_we_d = 1'b1;
        end else if (to_cnt_q == TO_LAST) begin
          state_d  = S_HALT;
          err_d    = ERR_TIMEOUT;
          to_cnt_d = to_cnt_q + 1'b1;
        end else begin
          req_d    = 1'b1;
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        to_cnt_d = '0;
        case (itype_i)
          LTYPE: begin
            state_d = S_MEM;
            req_d   = 1'b1;
          end
          STYPE: begin
            state_d = S_MEM;
            req_d   = 1'b1;
            we_d    = 1'b1;
          end
          BTYPE: begin
            state_d = S_FETCH;
            pc_we_d = 1'b1;
          end
          RTYPE, ITYPE, UTYPE, JTYPE, JRTYPE: begin
            state_d = S_WB;
            wd_d    = 1'b1;
            pc_we_d = 1'b1;
          end
          default: begin
            state_d = S_HALT;
            err_d   = ERR_ILLEGAL;
          end
        endcase
      end
      S_MEM: begin
        // mem_we_o remembers whether this access is a store or a load.
        if (mem_ready_i) begin
          to_cnt_d = '0;
          pc_we_d  = 1'b1;
          if (mem_we_o) begin
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
            wd_d    = 1'b1;
          end
        end else if (to_cnt_q == TO_LAST) begin
          state_d  = S_HALT;
          err_d    = ERR_TIMEOUT;
          to_cnt_d = to_cnt_q + 1'b1;
        end else begin
          req_d    = 1'b1;
          we_d     = mem_we_o;
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      S_WB: begin
        to_cnt_d = '0;
        state_d  = S_FETCH;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

`ifdef STAGE_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_cnt_o <= '0;
      retired_o   <= '0;
    end else begin
      if (state_q != S_HALT) cycle_cnt_o <= cycle_cnt_o + 32'd1;
      if (pc_we_o)           retired_o   <= retired_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_stage_ctrl.sv
// Directed bench for stage_ctrl: instruction flows, wait states, halt, illegal itype, timeout, reset mid-MEM.
// Performance counter checks are included when STAGE_CTRL_PERF_EN is defined.
module tb_stage_ctrl;

  localparam logic [4:0] RTYPE = 5'd0;
  localparam logic [4:0] ITYPE = 5'd1;
  localparam logic [4:0] LTYPE = 5'd2;
  localparam logic [4:0] STYPE = 5'd3;
  localparam logic [4:0] BTYPE = 5'd4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] itype_i = 5'd0;
  logic       mem_ready_i = 1'b0;
  logic       halt_i = 1'b0;
  logic [2:0] stage_o;
  logic       mem_req_o, mem_we_o, ir_we_o, pc_we_o, wd_q_o;
  logic [1:0] err_o;
`ifdef STAGE_CTRL_PERF_EN
  logic [31:0] cycle_cnt_o, retired_o;
`endif

  int passed = 0;
  int total  = 0;

  stage_ctrl #(.MEM_TIMEOUT(64), .TO_W(7)) dut (
    .clk(clk), .reset(reset), .itype_i(itype_i), .mem_ready_i(mem_ready_i), .halt_i(halt_i),
    .stage_o(stage_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .ir_we_o(ir_we_o),
    .pc_we_o(pc_we_o), .wd_q_o(wd_q_o), .err_o(err_o)
`ifdef STAGE_CTRL_PERF_EN
    , .cycle_cnt_o(cycle_cnt_o), .retired_o(retired_o)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1);
  end

  // Runs one instruction from a FETCH entry cycle until the next FETCH entry or HALT.
  task automatic run_instr(input logic [4:0] it, input int fwait, input int mwait, input logic hold_halt,
                           output int cycles, output int n_wd, output int n_pc, output int n_ir,
                           output int n_mreq, output int n_mwe, output logic [23:0] trace);
    int fl, ml;
    logic [2:0] last;
    bit done;
    fl = fwait; ml = mwait; cycles = 0; n_wd = 0; n_pc = 0; n_ir = 0; n_mreq = 0; n_mwe = 0;
    trace = '0; last = 3'd0; done = 0;
    itype_i = it;
    while (!done && cycles < 300) begin
      halt_i = (stage_o == 3'd0 && !mem_req_o) ? 1'b0 : hold_halt;
      mem_ready_i = 1'b0;
      if (stage_o == 3'd0 && mem_req_o) begin
        if (fl == 0) mem_ready_i = 1'b1; else fl--;
      end else if (stage_o == 3'd3 && mem_req_o) begin
        if (ml == 0) mem_ready_i = 1'b1; else ml--;
      end
      @(negedge clk);
      cycles++;
      n_wd += int'(wd_q_o);
      n_pc += int'(pc_we_o);
      n_ir += int'(ir_we_o);
      if (stage_o == 3'd3 && mem_req_o) n_mreq++;
      if (stage_o == 3'd3 && mem_req_o && mem_we_o) n_mwe++;
      if (stage_o != last) begin
        trace = {trace[20:0], stage_o};
        last = stage_o;
      end
      if ((stage_o == 3'd0 && !mem_req_o) || stage_o == 3'd5) done = 1;
    end
    halt_i = 1'b0;
    mem_ready_i = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; mem_ready_i = 1'b1; halt_i = 1'b1; itype_i = RTYPE;
    @(negedge clk);
    @(negedge clk);
    total++; if (stage_o !== 3'd0) $display("FAIL reset_stage: got %0d expected 0", stage_o); else passed++;
    total++; if (mem_req_o !== 1'b0) $display("FAIL reset_mem_req: got %0b expected 0", mem_req_o); else passed++;
    total++; if ({mem_we_o, ir_we_o, pc_we_o, wd_q_o} !== 4'b0)
      $display("FAIL reset_pulses: got %b expected 0000", {mem_we_o, ir_we_o, pc_we_o, wd_q_o}); else passed++;
    total++; if (err_o !== 2'd0) $display("FAIL reset_err: got %0d expected 0", err_o); else passed++;
`ifdef STAGE_CTRL_PERF_EN
    total++; if (cycle_cnt_o !== 32'd0 || retired_o !== 32'd0)
      $display("FAIL reset_perf: got %0d/%0d expected 0/0", cycle_cnt_o, retired_o); else passed++;
`endif
    reset = 1'b0; mem_ready_i = 1'b0; halt_i = 1'b0;
  endtask

  task automatic test_rtype();
    int c, wd, pc, ir, mr, mw;
    logic [23:0] tr;
    run_instr(RTYPE, 0, 0, 1'b0, c, wd, pc, ir, mr, mw, tr);
    total++; if (c !== 5) $display("FAIL rtype_latency: got %0d expected 5", c); else passed++;
    total++; if (tr !== 24'({3'd1, 3'd2, 3'd4, 3'd0})) $display("FAIL rtype_stages: got %h expected %h", tr, 24'({3'd1, 3'd2, 3'd4, 3'd0})); else passed++;
    total++; if (wd !== 1 || pc !== 1 || ir !== 1) $display("FAIL rtype_pulses: got wd=%0d pc=%0d ir=%0d expected 1/1/1", wd, pc, ir); else passed++;
`ifdef STAGE_CTRL_PERF_EN
    total++; if (cycle_cnt_o !== 32'd5 || retired_o !== 32'd1)
      $display("FAIL rtype_perf: got %0d/%0d expected 5/1", cycle_cnt_o, retired_o); else passed++;
`endif
  endtask

  task automatic test_load();
    int c, wd, pc, ir, mr, mw;
    logic [23:0] tr;
    run_instr(LTYPE, 0, 3, 1'b0, c, wd, pc, ir, mr, mw, tr);
    total++; if (c !== 9) $display("FAIL load_latency: got %0d expected 9", c); else passed++;
    total++; if (mr !== 4 || mw !== 0) $display("FAIL load_mem_req: got req=%0d we=%0d expected 4/0", mr, mw); else passed++;
    total++; if (tr !== 24'({3'd1, 3'd2, 3'd3, 3'd4, 3'd0})) $display("FAIL load_stages: got %h expected %h", tr, 24'({3'd1, 3'd2, 3'd3, 3'd4, 3'd0})); else passed++;
    total++; if (wd !== 1 || pc !== 1) $display("FAIL load_pulses: got wd=%0d pc=%0d expected 1/1", wd, pc); else passed++;
  endtask

  task automatic test_store();
    int c, wd, pc, ir, mr, mw;
    logic [23:0] tr;
    run_instr(STYPE, 0, 0, 1'b0, c, wd, pc, ir, mr, mw, tr);
    total++; if (c !== 5) $display("FAIL store_latency: got %0d expected 5", c); else passed++;
    total++; if (mr !== 1 || mw !== 1) $display("FAIL store_mem_we: got req=%0d we=%0d expected 1/1", mr, mw); else passed++;
    total++; if (wd !== 0 || pc !== 1) $display("FAIL store_pulses: got wd=%0d pc=%0d expected 0/1", wd, pc); else passed++;
    total++; if (tr !== 24'({3'd1, 3'd2, 3'd3, 3'd0})) $display("FAIL store_stages: got %h expected %h", tr, 24'({3'd1, 3'd2, 3'd3, 3'd0})); else passed++;
  endtask

  task automatic test_branch();
    int c, wd, pc, ir, mr, mw;
    logic [23:0] tr;
    run_instr(BTYPE, 0, 0, 1'b0, c, wd, pc, ir, mr, mw, tr);
    total++; if (c !== 4) $display("FAIL branch_latency: got %0d expected 4", c); else passed++;
    total++; if (tr !== 24'({3'd1, 3'd2, 3'd0})) $display("FAIL branch_stages: got %h expected %h", tr, 24'({3'd1, 3'd2, 3'd0})); else passed++;
    total++; if (wd !== 0 || pc !== 1 || mr !== 0) $display("FAIL branch_pulses: got wd=%0d pc=%0d memreq=%0d expected 0/1/0", wd, pc, mr); else passed++;
  endtask

  task automatic test_itype_wait_halt_ignored();
    int c, wd, pc, ir, mr, mw;
    logic [23:0] tr;
    run_instr(ITYPE, 2, 0, 1'b1, c, wd, pc, ir, mr, mw, tr);
    total++; if (c !== 7) $display("FAIL itype_wait_latency: got %0d expected 7", c); else passed++;
    total++; if (stage_o !== 3'd0 || err_o !== 2'd0) $display("FAIL itype_halt_ignored: got stage=%0d err=%0d expected 0/0", stage_o, err_o); else passed++;
  endtask

  task automatic test_halt();
    bit bad;
    halt_i = 1'b1; mem_ready_i = 1'b1;
    @(negedge clk);
    halt_i = 1'b0;
    total++; if (stage_o !== 3'd5 || mem_req_o !== 1'b0) $display("FAIL halt_entry: got stage=%0d req=%0b expected 5/0", stage_o, mem_req_o); else passed++;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (stage_o !== 3'd5 || mem_req_o !== 1'b0 || err_o !== 2'd0) bad = 1;
    end
    total++; if (bad) $display("FAIL halt_stays: got stage=%0d err=%0d expected 5/0", stage_o, err_o); else passed++;
    mem_ready_i = 1'b0;
  endtask

  task automatic test_illegal();
    int c, wd, pc, ir, mr, mw;
    logic [23:0] tr;
    bit bad;
    do_reset();
    run_instr(5'h1F, 0, 0, 1'b0, c, wd, pc, ir, mr, mw, tr);
    total++; if (c !== 4 || stage_o !== 3'd5) $display("FAIL illegal_halt: got cycles=%0d stage=%0d expected 4/5", c, stage_o); else passed++;
    total++; if (err_o !== 2'd1) $display("FAIL illegal_err: got %0d expected 1", err_o); else passed++;
    bad = 0;
    itype_i = RTYPE; mem_ready_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (stage_o !== 3'd5 || mem_req_o || ir_we_o || pc_we_o || wd_q_o || err_o !== 2'd1) bad = 1;
    end
    total++; if (bad) $display("FAIL illegal_sticky: got stage=%0d err=%0d expected 5/1", stage_o, err_o); else passed++;
    mem_ready_i = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total++; if (stage_o !== 3'd0 || err_o !== 2'd0) $display("FAIL illegal_reset: got stage=%0d err=%0d expected 0/0", stage_o, err_o); else passed++;
  endtask

  task automatic test_timeout();
    int n;
    n = 0;
    mem_ready_i = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (stage_o == 3'd0 && mem_req_o) n++;
      if (stage_o == 3'd5) break;
    end
    total++; if (n !== 64) $display("FAIL timeout_wait: got %0d expected 64", n); else passed++;
    total++; if (stage_o !== 3'd5 || err_o !== 2'd2) $display("FAIL timeout_err: got stage=%0d err=%0d expected 5/2", stage_o, err_o); else passed++;
  endtask

  task automatic test_timeout_edge();
    int c, wd, pc, ir, mr, mw;
    logic [23:0] tr;
    do_reset();
    run_instr(RTYPE, 63, 0, 1'b0, c, wd, pc, ir, mr, mw, tr);
    total++; if (c !== 68 || err_o !== 2'd0) $display("FAIL timeout_edge: got cycles=%0d err=%0d expected 68/0", c, err_o); else passed++;
    total++; if (wd !== 1 || stage_o !== 3'd0) $display("FAIL timeout_edge_wb: got wd=%0d stage=%0d expected 1/0", wd, stage_o); else passed++;
  endtask

  task automatic test_reset_mid_mem();
    itype_i = LTYPE;
    for (int i = 0; i < 20; i++) begin
      mem_ready_i = (stage_o == 3'd0 && mem_req_o);
      @(negedge clk);
      if (stage_o == 3'd3) break;
    end
    mem_ready_i = 1'b0;
    total++; if (stage_o !== 3'd3 || mem_req_o !== 1'b1) $display("FAIL midmem_setup: got stage=%0d req=%0b expected 3/1", stage_o, mem_req_o); else passed++;
    reset = 1'b1; mem_ready_i = 1'b1;
    @(negedge clk);
    reset = 1'b0; mem_ready_i = 1'b0;
    total++; if (stage_o !== 3'd0 || mem_req_o !== 1'b0) $display("FAIL midmem_abort: got stage=%0d req=%0b expected 0/0", stage_o, mem_req_o); else passed++;
    total++; if ({mem_we_o, ir_we_o, pc_we_o, wd_q_o} !== 4'b0)
      $display("FAIL midmem_pulses: got %b expected 0000", {mem_we_o, ir_we_o, pc_we_o, wd_q_o}); else passed++;
`ifdef STAGE_CTRL_PERF_EN
    total++; if (cycle_cnt_o !== 32'd0 || retired_o !== 32'd0)
      $display("FAIL midmem_perf: got %0d/%0d expected 0/0", cycle_cnt_o, retired_o); else passed++;
`endif
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_load();
    test_store();
    test_branch();
    test_itype_wait_halt_ignored();
    test_halt();
    test_illegal();
    test_timeout();
    test_timeout_edge();
    test_reset_mid_mem();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
